gb_cart_mem_bridge: RTL

Memory-side responder for the cartridge mapper's translated address. Takes one access at a time (24-bit physical address from the MBC, CPU read/write, ROM/RAM select) and runs a timed asynchronous-SRAM/flash cycle on the external cartridge memory pins. Sits between the MBC (address translation, ram_enabled) and the board-level ROM flash / save SRAM. Returns read data with a valid pulse to the CPU bus front end.

---
 rtl/gb_cart_mem_bridge.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gb_cart_mem_bridge.sv
// -----------------------------------------------------------------------------
// gb_cart_mem_bridge
//
// Memory-side responder for the cartridge mapper. Accepts one translated
// access at a time and runs a timed asynchronous SRAM/flash cycle on the
// external cartridge memory pins. It then returns a one-cycle completion pulse
// together with the read data.
//
// Cycle shape (full access):
//   IDLE -> SETUP (1) -> STROBE (WAIT_CYCLES+1) -> RECOVER (1) -> DONE (1) -> IDLE
// Short path (no pin activity): IDLE -> DONE -> IDLE. It is used for:
//   - RAM access while the latched ram_enabled is 0
//   - ROM writes
//   - read-cache hits (optional feature)
//
// Optional feature: define GB_CART_BRIDGE_RDCACHE_EN to add a one-entry ROM
// read cache. Without the macro, every read performs the full external cycle.
//
// Ports:
//   clock, rst           system clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while IDLE)
//   req_we, req_ram      access type: write / RAM select
//   req_addr, req_wdata  physical address from the MBC, write data
//   ram_enabled          MBC RAM enable, sampled at acceptance
//   resp_valid           one-cycle completion pulse (reads and writes)
//   resp_rdata           read data, held until the next read completes
//   rom_ce_n, ram_ce_n   chip enables (active-low)
//   mem_oe_n, mem_we_n   output / write strobes (active-low)
//   mem_addr             external address
//   mem_dq_out           write data driven to the pins
//   mem_dq_oe            1 = drive mem_dq_out onto the pins
//   mem_dq_in            data returned by the pins
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module gb_cart_mem_bridge #(
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter int unsigned ROM_ADDR_BITS = 23,
  parameter int unsigned RAM_ADDR_BITS = 9,
  parameter bit          MBC2_NIBBLE   = 1'b1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_ram,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        ram_enabled,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        rom_ce_n,
  output logic        ram_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_dq_out,
  output logic        mem_dq_oe,
  input  logic [7:0]  mem_dq_in
);

  // Address masks: bits above the forwarded width are forced to zero.
  localparam logic [23:0] ROM_MASK = (ROM_ADDR_BITS >= 24) ? 24'hFF_FFFF
                                   : 24'((32'd1 << ROM_ADDR_BITS) - 32'd1);
  localparam logic [23:0] RAM_MASK = (RAM_ADDR_BITS >= 24) ? 24'hFF_FFFF
                                   : 24'((32'd1 << RAM_ADDR_BITS) - 32'd1);
  localparam logic [3:0]  STROBE_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RECOVER,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [3:0]  strobe_cnt_q;   // remaining STROBE cycles after the current one
  logic        we_q;
  logic        ram_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [7:0]  resp_rdata_q;
  logic        rom_ce_n_q;
  logic        ram_ce_n_q;
  logic        mem_oe_n_q;
  logic        mem_we_n_q;
  logic [23:0] mem_addr_q;
  logic [7:0]  mem_dq_out_q;
  logic        mem_dq_oe_q;

  // Decoded values for the request currently presented on the inputs.
  logic [23:0] addr_d;
  logic [7:0]  wdata_d;
  logic [7:0]  rdata_d;
  logic        bypass_d;
  logic        cache_hit;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_d  = req_addr & (req_ram ? RAM_MASK : ROM_MASK);
    wdata_d = req_wdata;
    rdata_d = mem_dq_in;
    if (MBC2_NIBBLE && req_ram) begin
      wdata_d = {4'hF, req_wdata[3:0]};
    end
    // MBC2 RAM only stores a nibble; the upper bits read back as ones.
    if (MBC2_NIBBLE && ram_q) begin
      rdata_d = {4'hF, mem_dq_in[3:0]};
    end
  end

  // Accesses that never reach the pins: disabled RAM and any ROM write.
  assign bypass_d = req_ram ? !ram_enabled : req_we;

`ifdef GB_CART_BRIDGE_RDCACHE_EN
  // One-entry ROM read cache. Only ROM reads fill it, so the RAM-select part
  // of the tag is always zero and the stored address alone identifies it.
  logic        cache_valid_q;
  logic [23:0] cache_tag_q;
  logic [7:0]  cache_data_q;

  assign cache_hit = cache_valid_q && !req_ram && !req_we && (cache_tag_q == addr_d);
`else
  assign cache_hit = 1'b0;
`endif

  // NOTE: state and every registered output are updated with non-blocking
  // assignments, so all of them see the same pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      strobe_cnt_q <= 4'd0;
      we_q         <= 1'b0;
      ram_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'hFF;
      rom_ce_n_q   <= 1'b1;
      ram_ce_n_q   <= 1'b1;
      mem_oe_n_q   <= 1'b1;
      mem_we_n_q   <= 1'b1;
      mem_addr_q   <= 24'd0;
      mem_dq_out_q <= 8'd0;
      mem_dq_oe_q  <= 1'b0;
`ifdef GB_CART_BRIDGE_RDCACHE_EN
      // The whole cache entry is reset; it is a single small register, so
      // clearing the data along with the valid bit costs nothing.
      cache_valid_q <= 1'b0;
      cache_tag_q   <= 24'd0;
      cache_data_q  <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          if (req_valid) begin
            // req_ready is high throughout IDLE, so req_valid alone accepts.
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            ram_q       <= req_ram;
`ifdef GB_CART_BRIDGE_RDCACHE_EN
            if (req_we || req_ram) begin
              cache_valid_q <= 1'b0;
            end
`endif
            if (bypass_d || cache_hit) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              if (!req_we) begin
`ifdef GB_CART_BRIDGE_RDCACHE_EN
                resp_rdata_q <= cache_hit ? cache_data_q : 8'hFF;
`else
                resp_rdata_q <= 8'hFF;
`endif
              end
            end else begin
              state_q      <= S_SETUP;
              strobe_cnt_q <= STROBE_LOAD;
              mem_addr_q   <= addr_d;
              rom_ce_n_q   <= req_ram;
              ram_ce_n_q   <= !req_ram;
              if (req_we) begin
                mem_dq_out_q <= wdata_d;
                mem_dq_oe_q  <= 1'b1;
              end
            end
          end
        end

        S_SETUP: begin
          // Address and chip enable have been stable for one cycle; open the
          // strobe that matches the access direction.
          state_q <= S_STROBE;
          if (we_q) begin
            mem_we_n_q <= 1'b0;
          end else begin
            mem_oe_n_q <= 1'b0;
          end
        end

        S_STROBE: begin
          if (strobe_cnt_q == 4'd0) begin
            state_q    <= S_RECOVER;
            mem_oe_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
            if (!we_q) begin
              // Sample the pins on the last edge the output enable is still low.
              resp_rdata_q <= rdata_d;
`ifdef GB_CART_BRIDGE_RDCACHE_EN
              if (!ram_q) begin
                cache_valid_q <= 1'b1;
                cache_tag_q   <= mem_addr_q;
                cache_data_q  <= mem_dq_in;
              end
`endif
            end
          end else begin
            strobe_cnt_q <= strobe_cnt_q - 4'd1;
          end
        end

        S_RECOVER: begin
          // Chip enable and write data were held one cycle past the strobe
          // for hold time; release everything now.
          state_q      <= S_DONE;
          rom_ce_n_q   <= 1'b1;
          ram_ce_n_q   <= 1'b1;
          mem_dq_oe_q  <= 1'b0;
          resp_valid_q <= 1'b1;
        end

        S_DONE: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end

        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          rom_ce_n_q   <= 1'b1;
          ram_ce_n_q   <= 1'b1;
          mem_oe_n_q   <= 1'b1;
          mem_we_n_q   <= 1'b1;
          mem_dq_oe_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign rom_ce_n   = rom_ce_n_q;
  assign ram_ce_n   = ram_ce_n_q;
  assign mem_oe_n   = mem_oe_n_q;
  assign mem_we_n   = mem_we_n_q;
  assign mem_addr   = mem_addr_q;
  assign mem_dq_out = mem_dq_out_q;
  assign mem_dq_oe  = mem_dq_oe_q;

endmodule
